// File: rtl/ram_access_ctrl_if.sv
// CPU/RAM bus bundle for ram_access_ctrl: MOV/MOC request side plus byte-wide RAM port.
interface ram_access_ctrl_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              mov;
  logic              rw;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              moc;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic              mem_re;

  modport master (
    output mov, rw, size, addr, data_in, mem_rdata,
    input  data_out, moc, err, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  mov, rw, size, addr, data_in, mem_rdata,
    output data_out, moc, err, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sequences one CPU memory request into 1/2/4 big-endian byte cycles on a byte-wide RAM.
// Optional macro ALIGN_CHECK_EN rejects misaligned halfword/word requests with err.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  ram_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state;
  logic [1:0]        r_k, w_k;
  logic [1:0]        r_nm1, w_nm1;
  logic              r_rw, w_rw;
  logic [ADDR_W-1:0] r_base, w_base;
  logic [31:0]       r_wdata, w_wdata;
  logic [31:0]       r_acc, w_acc;
  logic [31:0]       r_data_out, w_data_out;
  logic              r_moc, w_moc;
  logic              r_err, w_err;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [7:0]        r_mem_wdata, w_mem_wdata;
  logic              r_mem_we, w_mem_we;
  logic              r_mem_re, w_mem_re;
  logic              w_bad;

  // Byte j of a 32-bit word, j=0 is the least significant byte
  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] j);
    case (j)
      2'd0:    byte_sel = d[7:0];
      2'd1:    byte_sel = d[15:8];
      2'd2:    byte_sel = d[23:16];
      default: byte_sel = d[31:24];
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  endfunction

  // Request rejection: reserved size, plus misalignment when checking is built in
  always_comb begin
`ifdef ALIGN_CHECK_EN
    w_bad = (bus.size == 2'b11) ||
            ((bus.size == 2'b01) && bus.addr[0]) ||
            ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    w_bad = (bus.size == 2'b11);
`endif
  end

  always_comb begin
    w_state     = r_state;
    w_k         = r_k;
    w_nm1       = r_nm1;
    w_rw        = r_rw;
    w_base      = r_base;
    w_wdata     = r_wdata;
    w_acc       = r_acc;
    w_data_out  = r_data_out;
    w_moc       = r_moc;
    w_err       = r_err;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_moc = 1'b0;
        w_err = 1'b0;
        if (bus.mov) begin
          w_base  = bus.addr;
          w_rw    = bus.rw;
          w_wdata = bus.data_in;
          w_nm1   = last_idx(bus.size);
          w_k     = 2'd0;
          w_acc   = 32'd0;
          if (w_bad) begin
            w_state = S_DONE;
            w_moc   = 1'b1;
            w_err   = 1'b1;
          end else begin
            w_state     = S_XFER;
            w_mem_addr  = bus.addr;
            w_mem_we    = ~bus.rw;
            w_mem_re    = bus.rw;
            w_mem_wdata = byte_sel(bus.data_in, last_idx(bus.size));
          end
        end
      end

      S_XFER: begin
        // Read data lags the strobe by one cycle, so cycle 0 has nothing to capture
        if (r_rw && (r_k != 2'd0)) begin
          w_acc = {r_acc[23:0], bus.mem_rdata};
        end
        if (r_k == r_nm1) begin
          w_state = r_rw ? S_DRAIN : S_DONE;
          w_moc   = ~r_rw;
        end else begin
          w_k         = r_k + 2'd1;
          w_mem_addr  = r_base + ADDR_W'(w_k);
          w_mem_we    = ~r_rw;
          w_mem_re    = r_rw;
          w_mem_wdata = byte_sel(r_wdata, r_nm1 - w_k);
        end
      end

      S_DRAIN: begin
        w_data_out = {r_acc[23:0], bus.mem_rdata};
        w_state    = S_DONE;
        w_moc      = 1'b1;
      end

      S_DONE: begin
        if (!bus.mov) begin
          w_state = S_IDLE;
          w_moc   = 1'b0;
          w_err   = 1'b0;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_moc   = 1'b0;
        w_err   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_k         <= 2'd0;
      r_nm1       <= 2'd0;
      r_rw        <= 1'b0;
      r_base      <= '0;
      r_wdata     <= 32'd0;
      r_acc       <= 32'd0;
      r_data_out  <= 32'd0;
      r_moc       <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_k         <= w_k;
      r_nm1       <= w_nm1;
      r_rw        <= w_rw;
      r_base      <= w_base;
      r_wdata     <= w_wdata;
      r_acc       <= w_acc;
      r_data_out  <= w_data_out;
      r_moc       <= w_moc;
      r_err       <= w_err;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_we    <= w_mem_we;
      r_mem_re    <= w_mem_re;
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.moc       = r_moc;
  assign bus.err       = r_err;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Random and directed bench for ram_access_ctrl against a byte-array model of RAM contents.
module tb_ram_access_ctrl;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [7:0]  ram     [DEPTH] = '{default: 8'h00};
  logic [7:0]  exp_mem [DEPTH] = '{default: 8'h00};
  logic [31:0] exp_dout;
  logic [31:0] dout;

  ram_access_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

  ram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM: write on strobe, read data valid the cycle after mem_re
  always @(posedge clk) begin
    if (bus_if.mem_we) ram[bus_if.mem_addr] <= bus_if.mem_wdata;
    if (bus_if.mem_re) bus_if.mem_rdata <= ram[bus_if.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_rejected(input logic [1:0] sz, input logic [8:0] a);
    bit bad;
    bad = (sz == 2'b11);
`ifdef ALIGN_CHECK_EN
    if (sz == 2'b01 && a[0]) bad = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
`endif
    return bad;
  endfunction

  // One full request: issue, wait for moc, hold, release, and compare against the model
  task automatic do_req(input bit rw, input logic [1:0] sz, input logic [8:0] a,
                        input logic [31:0] d, input int hold, output logic [31:0] res);
    int          n, edges, nwe, nre, exp_edges;
    bit          bad, done;
    logic [31:0] exp_rd;
    logic [8:0]  ai;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad = is_rejected(sz, a);
    exp_edges = bad ? 1 : (rw ? n + 2 : n + 1);
    exp_rd = 32'd0;
    for (int i = 0; i < n; i++) begin
      ai = a + 9'(i);
      exp_rd = (exp_rd << 8) | 32'(exp_mem[ai]);
    end

    @(negedge clk);
    bus_if.mov = 1'b1; bus_if.rw = rw; bus_if.size = sz;
    bus_if.addr = a;   bus_if.data_in = d;
    edges = 0; nwe = 0; nre = 0; done = 1'b0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        bus_if.rw = 1'($urandom); bus_if.size = 2'($urandom);
        bus_if.addr = 9'($urandom); bus_if.data_in = $urandom;
      end
      if (bus_if.mem_we) nwe++;
      if (bus_if.mem_re) nre++;
      if (bus_if.mem_we && bus_if.mem_re) check("strobe_excl", 32'd1, 32'd0);
      if (bus_if.moc) done = 1'b1;
    end
    check("latency", 32'(edges), 32'(exp_edges));
    check("err", 32'(bus_if.err), 32'(bad));
    check("we_cycles", 32'(nwe), (!bad && !rw) ? 32'(n) : 32'd0);
    check("re_cycles", 32'(nre), (!bad && rw) ? 32'(n) : 32'd0);
    if (!bad && rw) begin
      exp_dout = exp_rd;
      check("read_data", bus_if.data_out, exp_rd);
    end else if (bad) begin
      check("err_dout_kept", bus_if.data_out, exp_dout);
    end
    if (!bad && !rw) begin
      for (int i = 0; i < n; i++) begin
        ai = a + 9'(i);
        exp_mem[ai] = 8'(d >> (8 * (n - 1 - i)));
        check("ram_byte", 32'(ram[ai]), 32'(exp_mem[ai]));
      end
    end
    res = bus_if.data_out;

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_moc", 32'(bus_if.moc), 32'd1);
      check("hold_idle", 32'(bus_if.mem_we | bus_if.mem_re), 32'd0);
    end
    @(negedge clk);
    bus_if.mov = 1'b0;
    @(posedge clk); #1;
    check("moc_drop", 32'(bus_if.moc), 32'd0);
    check("err_clear", 32'(bus_if.err), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_dout = 32'd0;
    reset = 1'b0;
    bus_if.mov = 1'b0; bus_if.rw = 1'b0; bus_if.size = 2'b00;
    bus_if.addr = '0; bus_if.data_in = 32'd0; bus_if.mem_rdata = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_moc", 32'(bus_if.moc), 32'd0);
    check("rst_err", 32'(bus_if.err), 32'd0);
    check("rst_strobes", 32'({bus_if.mem_we, bus_if.mem_re}), 32'd0);
    check("rst_dout", bus_if.data_out, 32'd0);
    check("rst_maddr", 32'(bus_if.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus_if.mem_wdata), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Reset in the middle of a word write: first byte stays, strobes drop at once
    @(negedge clk);
    bus_if.mov = 1'b1; bus_if.rw = 1'b0; bus_if.size = 2'b10;
    bus_if.addr = 9'h100; bus_if.data_in = 32'hA1B2C3D4;
    @(posedge clk); #1;
    check("mid_we", 32'(bus_if.mem_we), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; bus_if.mov = 1'b0;
    #1;
    check("mid_rst_moc", 32'(bus_if.moc), 32'd0);
    check("mid_rst_we", 32'(bus_if.mem_we), 32'd0);
    exp_mem[9'h100] = 8'hA1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 32'({bus_if.moc, bus_if.mem_we, bus_if.mem_re}), 32'd0);
    check("kept_byte", 32'(ram[9'h100]), 32'hA1);
    check("unwritten_byte", 32'(ram[9'h101]), 32'h00);

    do_req(1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 0, dout);
    check("ww_b0", 32'(ram[9'h010]), 32'hDE);
    check("ww_b3", 32'(ram[9'h013]), 32'hEF);
    do_req(1'b1, 2'b10, 9'h010, 32'h0, 0, dout);
    check("wr_deadbeef", dout, 32'hDEADBEEF);
    do_req(1'b1, 2'b00, 9'h011, 32'h0, 0, dout);
    check("br_ad", dout, 32'h000000AD);
    do_req(1'b1, 2'b11, 9'h020, 32'h0, 0, dout);
    check("rsv_dout", dout, 32'h000000AD);
    do_req(1'b0, 2'b01, 9'h1FF, 32'h00001234, 0, dout);
`ifndef ALIGN_CHECK_EN
    check("hw_wrap_hi", 32'(ram[9'h1FF]), 32'h12);
    check("hw_wrap_lo", 32'(ram[9'h000]), 32'h34);
`endif
    do_req(1'b1, 2'b10, 9'h002, 32'h0, 0, dout);
    do_req(1'b0, 2'b10, 9'h1FF, 32'h01020304, 10, dout);
    do_req(1'b1, 2'b10, 9'h1FF, 32'h0, 0, dout);

    for (int t = 0; t < 60; t++) begin
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 9'($urandom), $urandom,
             int'($urandom_range(0, 3)), dout);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
